furv_rf_sb: RTL and testbench

Parametrised register file with integrated counting scoreboard and writeback bypass for the furv core; successor to the single-bit-lock register file. Decode reads NRD source operands plus per-operand ready flags, and locks a destination. NWB writeback ports write values and release locks. Per-register pending counters allow several in-flight writes to one register, and a flush clears all locks.

---
 rtl/furv_pkg.sv | 13 +
 rtl/furv_sb_counter.sv | 42 ++++
 rtl/furv_rf_sb.sv | 105 ++++++++++
 tb/tb_furv_rf_sb.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/furv_pkg.sv
// Shared definitions for the furv core: default data width, register index type
// and the hard-wired zero register.
package furv_pkg;

  localparam int FURV_XLEN  = 32;
  localparam int FURV_NREGS = 32;
  localparam int FURV_IDXW  = $clog2(FURV_NREGS);

  typedef logic [FURV_IDXW-1:0] reg_idx_t;

  localparam reg_idx_t X0 = '0;

endpackage

// File: rtl/furv_sb_counter.sv
// One scoreboard pending-write counter: +inc, -dec per cycle, clamped to
// [0, 2^CNTW-1], cleared by flush. sat marks that no further lock may be taken.
module furv_sb_counter #(
  parameter int CNTW = 2,
  parameter int DECW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic [DECW-1:0] dec,
  input  logic            flush,
  output logic [CNTW-1:0] cnt,
  output logic            sat
);

  localparam int SW = ((CNTW > DECW) ? CNTW : DECW) + 1;
  localparam logic [SW-1:0] CNT_MAX = SW'({CNTW{1'b1}});

  logic [SW-1:0] up;
  logic [SW-1:0] dn;
  logic [SW-1:0] nxt;

  // Clamp at zero so a stray release after a flush cannot wrap the counter.
  always_comb begin
    up  = SW'(cnt) + SW'(inc);
    dn  = SW'(dec);
    nxt = '0;
    if (flush || dn >= up) nxt = '0;
    else if (up - dn > CNT_MAX) nxt = CNT_MAX;
    else nxt = up - dn;
  end

  // NOTE: state updates use non-blocking assignments so every counter samples
  // the same pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= CNTW'(nxt);
  end

  assign sat = &cnt;

endmodule

// File: rtl/furv_rf_sb.sv
// furv register file with counting scoreboard: NRD bypassed read ports with
// ready flags, one lock port, NWB prioritised writeback/release ports, flush.
module furv_rf_sb
  import furv_pkg::*;
#(
  parameter int XLEN  = FURV_XLEN,
  parameter int NREGS = FURV_NREGS,
  parameter int NRD   = 2,
  parameter int NWB   = 2,
  parameter int CNTW  = 2,
  localparam int IDXW = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*IDXW-1:0]  de_rs_index,
  output logic [NRD*XLEN-1:0]  rf_rs,
  output logic [NRD-1:0]       rf_rs_ready,
  input  logic [IDXW-1:0]      de_lock_rd,
  input  logic                 de_lock_valid,
  output logic                 rf_lock_ok,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic [NWB*IDXW-1:0]  wb_rel_rd,
  input  logic [NWB*XLEN-1:0]  wb_rd_value,
  input  logic [NWB-1:0]       wb_rd_ready,
  output logic [NREGS-1:0]     rf_busy
);

  localparam int NRW = $clog2(NWB + 1);
  localparam logic [IDXW-1:0] ZERO_IDX = IDXW'(X0);

  logic [XLEN-1:0]              regs [NREGS];
  logic [NREGS-1:0][CNTW-1:0]   cnt;
  logic [NREGS-1:0]             sat;
  logic [NRW-1:0]               nrel [NREGS];
  logic [IDXW-1:0]              wb_idx [NWB];
  logic [XLEN-1:0]              wb_val [NWB];
  logic [NWB-1:0]               rel;
  logic                         lk;

  for (genvar j = 0; j < NWB; j++) begin : g_wb
    assign wb_idx[j] = wb_rel_rd[j*IDXW +: IDXW];
    assign wb_val[j] = wb_rd_value[j*XLEN +: XLEN];
    assign rel[j]    = wb_rd_ready[j] && (wb_idx[j] != ZERO_IDX);
  end

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      nrel[i] = '0;
      for (int j = 0; j < NWB; j++)
        if (rel[j] && wb_idx[j] == IDXW'(i)) nrel[i] = nrel[i] + NRW'(1);
    end
  end

  assign rf_lock_ok = (de_lock_rd == ZERO_IDX) || !sat[de_lock_rd];
  assign lk = de_lock_valid && !stall_i && rf_lock_ok && (de_lock_rd != ZERO_IDX);

  assign cnt[0] = '0;
  assign sat[0] = 1'b0;
  for (genvar i = 1; i < NREGS; i++) begin : g_cnt
    furv_sb_counter #(.CNTW(CNTW), .DECW(NRW)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (lk && de_lock_rd == IDXW'(i)),
      .dec   (nrel[i]),
      .flush (flush_i),
      .cnt   (cnt[i]),
      .sat   (sat[i])
    );
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_busy
    assign rf_busy[i] = |cnt[i];
  end

  // NOTE: the value array is reset explicitly because reads of never-written
  // registers must return 0; this rules out mapping it onto a RAM macro.
  // Ascending port order means the last NBA, i.e. the highest port, wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int j = 0; j < NWB; j++)
        if (rel[j]) regs[wb_idx[j]] <= wb_val[j];
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [IDXW-1:0] idx;
    logic [XLEN-1:0] val;

    assign idx = de_rs_index[k*IDXW +: IDXW];

    always_comb begin
      val = regs[idx];
      for (int j = 0; j < NWB; j++)
        if (rel[j] && wb_idx[j] == idx) val = wb_val[j];
    end

    assign rf_rs[k*XLEN +: XLEN] = val;
    // Ready once the writes arriving this cycle cover every pending lock.
    assign rf_rs_ready[k] = (idx == ZERO_IDX) || (int'(cnt[idx]) <= int'(nrel[idx]));
  end

endmodule

// File: tb/tb_furv_rf_sb.sv
// Directed bench for furv_rf_sb: inputs change after the falling edge and
// outputs are checked 1 ns later, well before the next rising edge.
module tb_furv_rf_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWB   = 2;
  localparam int CNTW  = 2;
  localparam int IDXW  = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NRD*IDXW-1:0]  de_rs_index;
  logic [NRD*XLEN-1:0]  rf_rs;
  logic [NRD-1:0]       rf_rs_ready;
  logic [IDXW-1:0]      de_lock_rd;
  logic                 de_lock_valid;
  logic                 rf_lock_ok;
  logic                 stall_i;
  logic                 flush_i;
  logic [NWB*IDXW-1:0]  wb_rel_rd;
  logic [NWB*XLEN-1:0]  wb_rd_value;
  logic [NWB-1:0]       wb_rd_ready;
  logic [NREGS-1:0]     rf_busy;

  int n_cmp = 0;
  int n_err = 0;

  furv_rf_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWB(NWB), .CNTW(CNTW)) dut (
    .clk           (clk),
    .rst           (rst),
    .de_rs_index   (de_rs_index),
    .rf_rs         (rf_rs),
    .rf_rs_ready   (rf_rs_ready),
    .de_lock_rd    (de_lock_rd),
    .de_lock_valid (de_lock_valid),
    .rf_lock_ok    (rf_lock_ok),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .wb_rel_rd     (wb_rel_rd),
    .wb_rd_value   (wb_rd_value),
    .wb_rd_ready   (wb_rd_ready),
    .rf_busy       (rf_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    de_lock_rd    = '0;
    de_lock_valid = 1'b0;
    stall_i       = 1'b0;
    flush_i       = 1'b0;
    wb_rel_rd     = '0;
    wb_rd_value   = '0;
    wb_rd_ready   = '0;
  endtask

  task automatic tick();
    @(negedge clk);
    clear();
  endtask

  task automatic set_rd(input int k, input int idx);
    de_rs_index[k*IDXW +: IDXW] = IDXW'(idx);
  endtask

  task automatic lock(input int idx);
    de_lock_rd    = IDXW'(idx);
    de_lock_valid = 1'b1;
  endtask

  task automatic wb(input int j, input int idx, input logic [XLEN-1:0] val);
    wb_rel_rd[j*IDXW +: IDXW]   = IDXW'(idx);
    wb_rd_value[j*XLEN +: XLEN] = val;
    wb_rd_ready[j]              = 1'b1;
  endtask

  function automatic logic [XLEN-1:0] rs(input int k);
    return rf_rs[k*XLEN +: XLEN];
  endfunction

  initial begin
    clear();
    rst = 1'b1;
    de_rs_index = '0;
    #1;
    check("reset_busy", 64'(rf_busy), 64'h0);
    check("reset_rs", 64'(rf_rs), 64'h0);
    check("reset_ready", 64'(rf_rs_ready), 64'h3);
    check("reset_lock_ok", 64'(rf_lock_ok), 64'h1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-operation, without a clock edge
    wb(0, 5, 32'h0000_ABCD);
    tick();
    set_rd(0, 5);
    #1 check("pre_rst_val", 64'(rs(0)), 64'h0000_ABCD);
    lock(5);
    tick();
    lock(5);
    tick();
    #1 check("pre_rst_busy", 64'(rf_busy), 64'h20);
    check("pre_rst_ready", 64'(rf_rs_ready[0]), 64'h0);
    #2 rst = 1'b1;
    #1 check("async_rst_busy", 64'(rf_busy), 64'h0);
    check("async_rst_val", 64'(rs(0)), 64'h0);
    check("async_rst_ready", 64'(rf_rs_ready[0]), 64'h1);
    tick();
    rst = 1'b0;

    // Lock, wait, writeback with same-cycle bypass
    set_rd(0, 5);
    lock(5);
    tick();
    #1 check("lock_ready", 64'(rf_rs_ready[0]), 64'h0);
    check("lock_busy", 64'(rf_busy), 64'h20);
    tick();
    tick();
    wb(0, 5, 32'hDEAD_BEEF);
    #1 check("bypass_val", 64'(rs(0)), 64'hDEAD_BEEF);
    check("bypass_ready", 64'(rf_rs_ready[0]), 64'h1);
    tick();
    #1 check("rel_busy", 64'(rf_busy), 64'h0);
    check("array_val", 64'(rs(0)), 64'hDEAD_BEEF);

    // Stalled lock is not taken
    stall_i = 1'b1;
    lock(12);
    tick();
    #1 check("stall_busy", 64'(rf_busy), 64'h0);

    // Counter saturation on x7
    set_rd(1, 7);
    for (int n = 0; n < 3; n++) begin
      lock(7);
      tick();
    end
    de_lock_rd = 5'd7;
    #1 check("sat_lock_ok", 64'(rf_lock_ok), 64'h0);
    de_lock_valid = 1'b1;
    tick();
    #1 check("sat_busy", 64'(rf_busy), 64'h80);
    wb(1, 7, 32'h1);
    #1 check("sat_rel1_ready", 64'(rf_rs_ready[1]), 64'h0);
    tick();
    de_lock_rd = 5'd7;
    #1 check("unsat_lock_ok", 64'(rf_lock_ok), 64'h1);
    wb(1, 7, 32'h2);
    #1 check("sat_rel2_ready", 64'(rf_rs_ready[1]), 64'h0);
    tick();
    wb(1, 7, 32'h3);
    #1 check("sat_rel3_ready", 64'(rf_rs_ready[1]), 64'h1);
    check("sat_rel3_val", 64'(rs(1)), 64'h3);
    tick();
    #1 check("sat_done_busy", 64'(rf_busy), 64'h0);

    // Same-cycle lock and release of x3 with cnt=1
    set_rd(0, 3);
    lock(3);
    tick();
    lock(3);
    wb(0, 3, 32'h33);
    #1 check("lr_ready_now", 64'(rf_rs_ready[0]), 64'h1);
    tick();
    #1 check("lr_ready_next", 64'(rf_rs_ready[0]), 64'h0);
    check("lr_busy", 64'(rf_busy), 64'h8);
    check("lr_val", 64'(rs(0)), 64'h33);
    wb(0, 3, 32'h34);
    tick();
    #1 check("lr_clear_busy", 64'(rf_busy), 64'h0);

    // Both writeback ports hit x9; port 1 wins
    set_rd(1, 9);
    lock(9);
    tick();
    lock(9);
    tick();
    wb(0, 9, 32'h11);
    wb(1, 9, 32'h22);
    #1 check("dual_val", 64'(rs(1)), 64'h22);
    check("dual_ready", 64'(rf_rs_ready[1]), 64'h1);
    tick();
    #1 check("dual_busy", 64'(rf_busy), 64'h0);
    check("dual_array", 64'(rs(1)), 64'h22);

    // Flush discards locks, later stray release still writes
    set_rd(0, 4);
    lock(4);
    tick();
    #1 check("fl_busy_before", 64'(rf_busy), 64'h10);
    flush_i = 1'b1;
    lock(6);
    tick();
    #1 check("fl_busy_after", 64'(rf_busy), 64'h0);
    wb(0, 4, 32'h55);
    #1 check("fl_wb_val", 64'(rs(0)), 64'h55);
    check("fl_wb_ready", 64'(rf_rs_ready[0]), 64'h1);
    tick();
    #1 check("fl_stray_busy", 64'(rf_busy), 64'h0);
    check("fl_array", 64'(rs(0)), 64'h55);

    // x0 is never locked or written
    set_rd(0, 0);
    set_rd(1, 0);
    lock(0);
    wb(1, 0, 32'h77);
    #1 check("x0_lock_ok", 64'(rf_lock_ok), 64'h1);
    check("x0_val_now", 64'(rf_rs), 64'h0);
    tick();
    #1 check("x0_busy", 64'(rf_busy), 64'h0);
    check("x0_val", 64'(rf_rs), 64'h0);
    check("x0_ready", 64'(rf_rs_ready), 64'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
